// File: rtl/scoreboard.sv
//==============================================================================
// Module   : scoreboard (with package scoreboard_pkg)
// Brief    : In-order issue/commit scoreboard with per-port writeback by trans_id.
//            Optional macro SCOREBOARD_FORWARD_EN enables operand forwarding.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

package scoreboard_pkg;
    localparam int NR_SB_ENTRIES = 4;
    localparam int NR_WB_PORTS   = 2;
    localparam int TRANS_ID_BITS = $clog2(NR_SB_ENTRIES);

    typedef struct packed {
        logic [63:0] cause;
        logic [63:0] tval;
        logic        valid;
    } exception_t;

    typedef struct packed {
        logic [63:0]              pc;
        logic [TRANS_ID_BITS-1:0] trans_id;
        logic [4:0]               rs1;
        logic [4:0]               rs2;
        logic [4:0]               rd;
        logic [63:0]              result;
        logic                     valid;
        exception_t               ex;
    } scoreboard_entry_t;
endpackage

module scoreboard
    import scoreboard_pkg::*;
#(
    parameter int NR_ENTRIES = NR_SB_ENTRIES,
    parameter int NR_WB      = NR_WB_PORTS
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  flush_i,
    output logic                                  full_o,
    input  scoreboard_entry_t                     issue_instr_i,
    input  logic                                  issue_valid_i,
    output logic                                  issue_ack_o,
    output scoreboard_entry_t                     commit_instr_o,
    output logic                                  commit_valid_o,
    input  logic                                  commit_ack_i,
    input  logic [NR_WB-1:0][TRANS_ID_BITS-1:0]   trans_id_i,
    input  logic [NR_WB-1:0][63:0]                wdata_i,
    input  exception_t [NR_WB-1:0]                ex_i,
    input  logic [NR_WB-1:0]                      wb_valid_i,
    output logic [31:0]                           rd_clobber_o,
    input  logic [4:0]                            rs1_i,
    input  logic [4:0]                            rs2_i,
    output logic [63:0]                           rs1_o,
    output logic [63:0]                           rs2_o,
    output logic                                  rs1_valid_o,
    output logic                                  rs2_valid_o
);
    localparam int IDX_W = $clog2(NR_ENTRIES);

    scoreboard_entry_t      r_mem [NR_ENTRIES];
    logic [NR_ENTRIES-1:0]  r_occ;
    logic [IDX_W-1:0]       r_head;
    logic [IDX_W-1:0]       r_tail;
    logic [IDX_W:0]         r_count;

    logic                   w_accept;
    logic                   w_pop;
    scoreboard_entry_t      w_new;
    logic [31:0]            w_clobber;

    assign full_o         = (r_count == (IDX_W+1)'(NR_ENTRIES));
    assign issue_ack_o    = issue_valid_i & ~full_o & rst_ni & ~flush_i;
    assign w_accept       = issue_ack_o;
    assign commit_instr_o = r_mem[r_head];
    assign commit_valid_o = r_occ[r_head] & r_mem[r_head].valid;
    assign w_pop          = commit_ack_i & commit_valid_o;

    always_comb begin
        w_new          = issue_instr_i;
        w_new.trans_id = TRANS_ID_BITS'(r_tail);
        w_new.valid    = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni || flush_i) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_occ   <= '0;
            for (int i = 0; i < NR_ENTRIES; i++) begin
                r_mem[i].valid <= 1'b0;
            end
        end else begin
            // An accepted issue never targets an occupied slot, so it cannot collide with a writeback.
            if (w_accept) begin
                r_mem[r_tail] <= w_new;
                r_occ[r_tail] <= 1'b1;
                r_tail        <= r_tail + IDX_W'(1);
            end
            for (int p = 0; p < NR_WB; p++) begin
                if (wb_valid_i[p] && r_occ[trans_id_i[p]]) begin
                    r_mem[trans_id_i[p]].result <= wdata_i[p];
                    r_mem[trans_id_i[p]].valid  <= 1'b1;
                    if (ex_i[p].valid) begin
                        r_mem[trans_id_i[p]].ex <= ex_i[p];
                    end
                end
            end
            if (w_pop) begin
                r_occ[r_head] <= 1'b0;
                r_head        <= r_head + IDX_W'(1);
            end
            case ({w_accept, w_pop})
                2'b10:   r_count <= r_count + (IDX_W+1)'(1);
                2'b01:   r_count <= r_count - (IDX_W+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_comb begin
        w_clobber = '0;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (r_occ[i]) begin
                w_clobber[r_mem[i].rd] = 1'b1;
            end
        end
        w_clobber[0] = 1'b0;
    end
    assign rd_clobber_o = w_clobber;

`ifdef SCOREBOARD_FORWARD_EN
    logic [63:0] w_rs1_data;
    logic [63:0] w_rs2_data;
    logic        w_rs1_hit;
    logic        w_rs2_hit;

    // Walk oldest to youngest; the last match is the youngest producer.
    always_comb begin
        logic [IDX_W-1:0] idx;
        w_rs1_data = '0;
        w_rs2_data = '0;
        w_rs1_hit  = 1'b0;
        w_rs2_hit  = 1'b0;
        for (int k = 0; k < NR_ENTRIES; k++) begin
            idx = r_head + IDX_W'(k);
            if (r_occ[idx] && (r_mem[idx].rd == rs1_i)) begin
                w_rs1_hit  = r_mem[idx].valid & ~r_mem[idx].ex.valid;
                w_rs1_data = r_mem[idx].result;
            end
            if (r_occ[idx] && (r_mem[idx].rd == rs2_i)) begin
                w_rs2_hit  = r_mem[idx].valid & ~r_mem[idx].ex.valid;
                w_rs2_data = r_mem[idx].result;
            end
        end
    end

    assign rs1_valid_o = w_rs1_hit & (rs1_i != 5'd0);
    assign rs2_valid_o = w_rs2_hit & (rs2_i != 5'd0);
    assign rs1_o       = rs1_valid_o ? w_rs1_data : 64'd0;
    assign rs2_o       = rs2_valid_o ? w_rs2_data : 64'd0;
`else
    logic w_unused_rs;
    assign w_unused_rs = ^{rs1_i, rs2_i};
    assign rs1_o       = 64'd0;
    assign rs2_o       = 64'd0;
    assign rs1_valid_o = 1'b0;
    assign rs2_valid_o = 1'b0;
`endif

endmodule

`default_nettype wire
